frogger_traffic_engine: RTL and testbench
=========================================

Name: frogger_traffic_engine

Overview:
- Parametrised lane/traffic engine for the Frogger VGA game.
- Replaces the fixed set of per-car instances and the hand-written position and collision logic with a single configurable block.
- Each lane holds CARS_PER_LANE cars that step one tile per lane period, counted in video frames. The period shortens with game level.
- Serves a registered tile-hit query for the pixel renderer and produces a frog-collision pulse for the lives/frog control logic.

Parameters:
- NUM_LANES, 4, number of traffic lanes.
- CARS_PER_LANE, 2, cars per lane.
- GRID_W, 20, playfield width in tiles. Car X wraps modulo GRID_W.
- X_W, 5, tile-X width. Must satisfy 2^X_W >= GRID_W.
- Y_W, 4, tile-Y width.
- LVL_W, 7, level input width.
- LANE_ROW, lanes 0..3 = 12,11,10,9. Packed NUM_LANES*Y_W; lane l at [l*Y_W +: Y_W].
- LANE_DIR, lanes 0..3 = 1,0,1,0. NUM_LANES bits; 1 = rightward (+X), 0 = leftward.
- LANE_PERIOD, lanes 0..3 = 8,6,4,3. Packed NUM_LANES*8; frames per step at level 0.
- LANE_INIT_X, lane0 {0,7}, lane1 {19,12}, lane2 {3,9}, lane3 {4,18}. Packed NUM_LANES*CARS_PER_LANE*X_W; car c of lane l at [(l*CARS_PER_LANE+c)*X_W +: X_W].

Ports:
- i_Clk, in, 1, pixel clock.
- i_Reset, in, 1, synchronous active-high reset.
- i_Frame_Tick, in, 1, one-cycle pulse per video frame (VSync start).
- i_Enable, in, 1, 0 = traffic frozen and collision suppressed (pause/title).
- i_Level, in, LVL_W, current game level.
- i_Tile_X, in, X_W, renderer query column (pixel col >> 5).
- i_Tile_Y, in, Y_W, renderer query row.
- i_Frog_X, in, X_W, frog tile column.
- i_Frog_Y, in, Y_W, frog tile row.
- o_Car_Hit, out, 1, query tile holds a car.
- o_Car_Dir, out, 1, direction of the hit lane (for sprite mirroring); 0 when no hit.
- o_Collision, out, 1, one-cycle pulse when frog/car overlap begins.
- o_Step, out, NUM_LANES, per-lane one-cycle pulse when that lane stepped.

Behaviour:
- Reset (synchronous, active-high):
  - Car X positions = LANE_INIT_X.
  - Lane frame counters = 0.
  - Overlap history = 0.
  - o_Car_Hit, o_Car_Dir, o_Collision and o_Step = 0.
  - Reset wins over a simultaneous i_Frame_Tick.
- Effective period per lane: P_eff = max(1, LANE_PERIOD[l] - min(i_Level, 255)), computed as saturating 8-bit arithmetic.
- On each i_Frame_Tick with i_Enable=1, every lane's counter increments.
- When counter+1 >= P_eff:
  - The counter clears to 0.
  - All cars of that lane step ±1 in the same cycle.
  - o_Step[l] pulses in the cycle after the tick.
- The >= comparison means a level increase mid-count makes the lane step on its next tick; it never stalls.
- With i_Enable=0, counters and positions hold.
- Wrap-around:
  - Rightward: X = GRID_W-1 steps to 0.
  - Leftward: X = 0 steps to GRID_W-1.
  - X is never outside 0..GRID_W-1.
- Query:
  - Latency 1 cycle.
  - o_Car_Hit[t+1] = OR over all cars of (X==i_Tile_X[t] && LANE_ROW==i_Tile_Y[t]), evaluated on the positions current at cycle t.
  - If two lanes hit (overlapping rows), the lowest lane index sets o_Car_Dir.
- Collision:
  - overlap = any car matches (i_Frog_X, i_Frog_Y) && i_Enable.
  - Overlap is registered each cycle.
  - o_Collision = overlap && !overlap_q, a rising-edge pulse: exactly one pulse per contact, whether the frog moved into a car or a car stepped onto the frog.
  - A persistent overlap never re-pulses.
  - Deasserting i_Enable clears overlap, so re-enabling while overlapped pulses once.

Optional Feature:
- Macro TRAFFIC_RANDOM_GAP_EN.
- When defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every i_Frame_Tick.
  - When a car wraps, it parks for LFSR[1:0] extra lane steps before reappearing: a per-car 2-bit hold counter; the X update is suppressed while the counter is nonzero.
  - Parked cars report no hit and no collision.
- When undefined: no LFSR and no hold counters; wrap is immediate as above.

Decomposition:
- Package frogger_pkg holds:
  - TILE_SHIFT=5
  - default GRID_W/GRID_H constants
  - lane-direction encoding constants DIR_LEFT=0, DIR_RIGHT=1
  - a function sat_period(base, level) returning P_eff
- Sub-module frogger_lane (one per lane via generate) owns:
  - that lane's counter and car X registers
  - wrap logic and the optional hold counters
  - a per-lane hit/match vector
- The top ORs and priority-encodes the lane outputs.

Test Plan:
- Reset, level 0, enable=1, 8 frame ticks → lane0 car0 X 0→1, o_Step[0] single pulse after 8th tick; lane3 (period 3) stepped twice, car0 X 4→2.
- Lane0 car at 19, rightward, one step → X=0. Lane1 car at 0, leftward, one step → X=19. No hit reported at X=20.
- Level 5 → lane0 P_eff=3 (steps every 3 ticks). Level 10 → lanes 0..3 all P_eff=1 (step every tick). Raise level from 0 to 6 at count 4 on lane0 → steps on next tick.
- Frog at (1,12), lane0 car0 steps 0→1 → o_Collision one pulse. Held 20 cycles → no further pulse. Frog moves to (2,12) then back to (1,12) → second pulse.
- Query i_Tile=(7,12) after reset → o_Car_Hit=1, o_Car_Dir=1 one cycle later. Query (8,12) → 0. Back-to-back queries every cycle → correct per-cycle results.
- enable=0 for 20 ticks → no position change and no collision with frog on a car. Assert i_Reset together with i_Frame_Tick mid-run → all positions = LANE_INIT_X next cycle.

Source files
------------

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared constants and helpers for the Frogger traffic engine.
// Contents: tile shift, default playfield size, lane direction encoding,
// and sat_period() which yields the level-adjusted lane period (>= 1).
package frogger_pkg;
    localparam int TILE_SHIFT = 5;
    localparam int DEF_GRID_W = 20;
    localparam int DEF_GRID_H = 15;
    localparam logic DIR_LEFT = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [7:0] sat_period(input logic [7:0] base, input logic [7:0] level);
        logic [7:0] d;
        d = (base > level) ? base - level : 8'd0;
        return (d == 8'd0) ? 8'd1 : d;
    endfunction
endpackage

// File: rtl/frogger_lane.sv
// frogger_lane: one traffic lane -- frame counter, car X registers, wrap logic.
// Ports: i_Clk, i_Reset (sync, active-high), i_Tick (gated frame tick),
//   i_Level (saturated 8-bit level), i_Tile_X/Y (render query), i_Frog_X/Y,
//   i_Gap (park length, TRAFFIC_RANDOM_GAP_EN only), o_Step (registered step
//   pulse), o_Hit / o_Overlap (combinational query / frog match for this lane).
// Optional: TRAFFIC_RANDOM_GAP_EN adds per-car hold counters that park a car
// after it wraps.
module frogger_lane
    import frogger_pkg::*;
#(
    parameter int CARS = 2,
    parameter int GRID_W = DEF_GRID_W,
    parameter int X_W = 5,
    parameter int Y_W = 4,
    parameter logic [Y_W-1:0] ROW = '0,
    parameter logic DIR = DIR_RIGHT,
    parameter logic [7:0] PERIOD = 8'd8,
    parameter logic [CARS*X_W-1:0] INIT_X = '0
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    input  logic           i_Tick,
    input  logic [7:0]     i_Level,
    input  logic [X_W-1:0] i_Tile_X,
    input  logic [Y_W-1:0] i_Tile_Y,
    input  logic [X_W-1:0] i_Frog_X,
    input  logic [Y_W-1:0] i_Frog_Y,
`ifdef TRAFFIC_RANDOM_GAP_EN
    input  logic [1:0]     i_Gap,
`endif
    output logic           o_Step,
    output logic           o_Hit,
    output logic           o_Overlap
);
    logic [7:0] cnt;
    logic [7:0] p_eff;
    logic step;
    logic [X_W-1:0] car_x [CARS];
    logic [X_W-1:0] nx [CARS];
    logic [CARS-1:0] wrap, vis, hit_v, ov_v;
`ifdef TRAFFIC_RANDOM_GAP_EN
    logic [1:0] hold [CARS];
`endif

    always_comb begin
        p_eff = sat_period(PERIOD, i_Level);
        // >= rather than == so a period shortened mid-count steps on the next tick
        step = i_Tick && (({1'b0, cnt} + 9'd1) >= {1'b0, p_eff});
        for (int c = 0; c < CARS; c++) begin
            wrap[c] = DIR ? (car_x[c] == X_W'(GRID_W - 1)) : (car_x[c] == '0);
            nx[c] = wrap[c] ? (DIR ? '0 : X_W'(GRID_W - 1))
                            : (DIR ? car_x[c] + 1'b1 : car_x[c] - 1'b1);
`ifdef TRAFFIC_RANDOM_GAP_EN
            vis[c] = hold[c] == 2'd0;
`else
            vis[c] = 1'b1;
`endif
            hit_v[c] = vis[c] && (car_x[c] == i_Tile_X) && (ROW == i_Tile_Y);
            ov_v[c] = vis[c] && (car_x[c] == i_Frog_X) && (ROW == i_Frog_Y);
        end
        o_Hit = |hit_v;
        o_Overlap = |ov_v;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt <= '0;
            o_Step <= 1'b0;
            for (int c = 0; c < CARS; c++) begin
                car_x[c] <= INIT_X[c*X_W +: X_W];
`ifdef TRAFFIC_RANDOM_GAP_EN
                hold[c] <= '0;
`endif
            end
        end else begin
            o_Step <= step;
            if (i_Tick)
                cnt <= step ? 8'd0 : cnt + 8'd1;
            if (step) begin
                for (int c = 0; c < CARS; c++) begin
`ifdef TRAFFIC_RANDOM_GAP_EN
                    // a parked car burns lane steps in place, then resumes
                    if (hold[c] != 2'd0) begin
                        hold[c] <= hold[c] - 2'd1;
                    end else begin
                        car_x[c] <= nx[c];
                        if (wrap[c])
                            hold[c] <= i_Gap;
                    end
`else
                    car_x[c] <= nx[c];
`endif
                end
            end
        end
    end
endmodule

// File: rtl/frogger_traffic_engine.sv
// frogger_traffic_engine: parametrised lane/traffic engine for the Frogger VGA game.
// Ports: i_Clk, i_Reset (sync, active-high), i_Frame_Tick, i_Enable, i_Level,
//   i_Tile_X/Y (render query), i_Frog_X/Y; o_Car_Hit / o_Car_Dir (query result,
//   1-cycle latency), o_Collision (frog contact pulse), o_Step (per-lane step pulse).
// Optional: TRAFFIC_RANDOM_GAP_EN enables the LFSR-driven random parking gap.
module frogger_traffic_engine
    import frogger_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int CARS_PER_LANE = 2,
    parameter int GRID_W = DEF_GRID_W,
    parameter int X_W = 5,
    parameter int Y_W = 4,
    parameter int LVL_W = 7,
    parameter logic [NUM_LANES*Y_W-1:0] LANE_ROW = {4'd9, 4'd10, 4'd11, 4'd12},
    parameter logic [NUM_LANES-1:0] LANE_DIR = 4'b0101,
    parameter logic [NUM_LANES*8-1:0] LANE_PERIOD = {8'd3, 8'd4, 8'd6, 8'd8},
    parameter logic [NUM_LANES*CARS_PER_LANE*X_W-1:0] LANE_INIT_X =
        {5'd18, 5'd4, 5'd9, 5'd3, 5'd12, 5'd19, 5'd7, 5'd0}
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Frame_Tick,
    input  logic                 i_Enable,
    input  logic [LVL_W-1:0]     i_Level,
    input  logic [X_W-1:0]       i_Tile_X,
    input  logic [Y_W-1:0]       i_Tile_Y,
    input  logic [X_W-1:0]       i_Frog_X,
    input  logic [Y_W-1:0]       i_Frog_Y,
    output logic                 o_Car_Hit,
    output logic                 o_Car_Dir,
    output logic                 o_Collision,
    output logic [NUM_LANES-1:0] o_Step
);
    logic [7:0] lvl8;
    logic tick;
    logic [NUM_LANES-1:0] lane_hit, lane_ov;
    logic hit_dir, overlap, overlap_q;

    assign lvl8 = (32'(i_Level) > 32'd255) ? 8'd255 : 8'(i_Level);
    assign tick = i_Frame_Tick && i_Enable;

`ifdef TRAFFIC_RANDOM_GAP_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            lfsr <= 16'hACE1;
        else if (i_Frame_Tick)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        frogger_lane #(
            .CARS(CARS_PER_LANE),
            .GRID_W(GRID_W),
            .X_W(X_W),
            .Y_W(Y_W),
            .ROW(LANE_ROW[l*Y_W +: Y_W]),
            .DIR(LANE_DIR[l]),
            .PERIOD(LANE_PERIOD[l*8 +: 8]),
            .INIT_X(LANE_INIT_X[l*CARS_PER_LANE*X_W +: CARS_PER_LANE*X_W])
        ) u_lane (
            .i_Clk(i_Clk),
            .i_Reset(i_Reset),
            .i_Tick(tick),
            .i_Level(lvl8),
            .i_Tile_X(i_Tile_X),
            .i_Tile_Y(i_Tile_Y),
            .i_Frog_X(i_Frog_X),
            .i_Frog_Y(i_Frog_Y),
`ifdef TRAFFIC_RANDOM_GAP_EN
            .i_Gap(lfsr[1:0]),
`endif
            .o_Step(o_Step[l]),
            .o_Hit(lane_hit[l]),
            .o_Overlap(lane_ov[l])
        );
    end

    always_comb begin
        hit_dir = 1'b0;
        // walk from the highest lane down so the lowest hitting lane wins
        for (int l = NUM_LANES - 1; l >= 0; l--)
            hit_dir = lane_hit[l] ? LANE_DIR[l] : hit_dir;
        overlap = |lane_ov && i_Enable;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Car_Hit <= 1'b0;
            o_Car_Dir <= 1'b0;
            o_Collision <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            o_Car_Hit <= |lane_hit;
            o_Car_Dir <= hit_dir;
            o_Collision <= overlap && !overlap_q;
            overlap_q <= overlap;
        end
    end
endmodule

// File: tb/tb_frogger_traffic_engine.sv
// tb_frogger_traffic_engine: scoreboard bench for frogger_traffic_engine.
module tb_frogger_traffic_engine;
    logic i_Clk = 1'b0;
    logic i_Reset = 1'b0;
    logic i_Frame_Tick = 1'b0;
    logic i_Enable = 1'b0;
    logic [6:0] i_Level = '0;
    logic [4:0] i_Tile_X = '0;
    logic [3:0] i_Tile_Y = '0;
    logic [4:0] i_Frog_X = '0;
    logic [3:0] i_Frog_Y = '0;
    logic o_Car_Hit, o_Car_Dir, o_Collision;
    logic [3:0] o_Step;

    frogger_traffic_engine dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Frame_Tick(i_Frame_Tick),
        .i_Enable(i_Enable),
        .i_Level(i_Level),
        .i_Tile_X(i_Tile_X),
        .i_Tile_Y(i_Tile_Y),
        .i_Frog_X(i_Frog_X),
        .i_Frog_Y(i_Frog_Y),
        .o_Car_Hit(o_Car_Hit),
        .o_Car_Dir(o_Car_Dir),
        .o_Collision(o_Collision),
        .o_Step(o_Step)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic hit;
        logic dir;
        logic [3:0] stp;
        logic col;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int row_m[4] = '{12, 11, 10, 9};
    int dir_m[4] = '{1, 0, 1, 0};
    int per_m[4] = '{8, 6, 4, 3};
    int init_m[4][2] = '{'{0, 7}, '{19, 12}, '{3, 9}, '{4, 18}};
    int mx[4][2];
    int mcnt[4];
    bit mov_q;
    int st0_cnt, st3_cnt, col_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            mcnt[l] = 0;
            for (int c = 0; c < 2; c++) mx[l][c] = init_m[l][c];
        end
        mov_q = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset(input bit tick);
        i_Reset = 1'b1;
        i_Frame_Tick = tick;
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
        i_Frame_Tick = 1'b0;
        model_reset();
        check("rst_hit", 32'(o_Car_Hit), 0);
        check("rst_dir", 32'(o_Car_Dir), 0);
        check("rst_col", 32'(o_Collision), 0);
        check("rst_step", 32'(o_Step), 0);
    endtask

    // one clock: push expectations from the model for the current inputs, then compare
    task automatic cycle(input bit tick);
        exp_t e, g;
        bit ov;
        int p;
        e.hit = 1'b0;
        e.dir = 1'b0;
        e.stp = '0;
        ov = 1'b0;
        for (int l = 3; l >= 0; l--)
            for (int c = 0; c < 2; c++) begin
                if (mx[l][c] == int'(i_Tile_X) && row_m[l] == int'(i_Tile_Y)) begin
                    e.hit = 1'b1;
                    e.dir = dir_m[l][0];
                end
                if (mx[l][c] == int'(i_Frog_X) && row_m[l] == int'(i_Frog_Y)) ov = 1'b1;
            end
        ov = ov && i_Enable;
        e.col = ov && !mov_q;
        mov_q = ov;
        if (tick && i_Enable)
            for (int l = 0; l < 4; l++) begin
                p = per_m[l] - int'(i_Level);
                if (p < 1) p = 1;
                if (mcnt[l] + 1 >= p) begin
                    mcnt[l] = 0;
                    e.stp[l] = 1'b1;
                    for (int c = 0; c < 2; c++)
                        mx[l][c] = dir_m[l] == 1 ? (mx[l][c] + 1) % 20 : (mx[l][c] + 19) % 20;
                end else begin
                    mcnt[l]++;
                end
            end
        sb.push_back(e);
        i_Frame_Tick = tick;
        @(posedge i_Clk);
        #1;
        i_Frame_Tick = 1'b0;
        g = sb.pop_front();
        check("hit", 32'(o_Car_Hit), 32'(g.hit));
        check("dir", 32'(o_Car_Dir), 32'(g.dir));
        check("step", 32'(o_Step), 32'(g.stp));
        check("col", 32'(o_Collision), 32'(g.col));
        st0_cnt += int'(o_Step[0]);
        st3_cnt += int'(o_Step[3]);
        col_cnt += int'(o_Collision);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            i_Tile_X = 5'($urandom_range(0, 31));
            i_Tile_Y = 4'($urandom_range(8, 13));
            cycle(1'b0);
        end
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            cycle(1'b1);
            idle(gap);
        end
    endtask

    task automatic query(input int x, input int y);
        i_Tile_X = 5'(x);
        i_Tile_Y = 4'(y);
        cycle(1'b0);
    endtask

    task automatic scan();
        for (int y = 8; y <= 13; y++)
            for (int x = 0; x < 32; x++) query(x, y);
    endtask

    initial begin
        i_Enable = 1'b1;
        do_reset(1'b0);
        scan();

        // level 0: lane0 steps once in 8 ticks, lane3 twice
        st0_cnt = 0;
        st3_cnt = 0;
        ticks(8, 2);
        check("l0_steps", 32'(st0_cnt), 1);
        check("l3_steps", 32'(st3_cnt), 2);
        query(1, 12);
        check("l0c0_at1", 32'(o_Car_Hit), 1);
        query(2, 9);
        check("l3c0_at2", 32'(o_Car_Hit), 1);
        check("l3c0_dir", 32'(o_Car_Dir), 0);

        // wrap-around at level 10 (every lane steps every tick)
        do_reset(1'b0);
        i_Level = 7'd10;
        ticks(19, 0);
        query(19, 12);
        check("l0_at19", 32'(o_Car_Hit), 1);
        query(0, 11);
        check("l1_at0", 32'(o_Car_Hit), 1);
        ticks(1, 0);
        query(0, 12);
        check("l0_wrap0", 32'(o_Car_Hit), 1);
        check("l0_wrap_dir", 32'(o_Car_Dir), 1);
        query(19, 11);
        check("l1_wrap19", 32'(o_Car_Hit), 1);
        check("l1_wrap_dir", 32'(o_Car_Dir), 0);
        query(20, 12);
        check("x20_nohit", 32'(o_Car_Hit), 0);
        ticks(25, 1);
        scan();

        // level 5: lane0 period 3
        do_reset(1'b0);
        i_Level = 7'd5;
        st0_cnt = 0;
        ticks(9, 1);
        check("lvl5_steps", 32'(st0_cnt), 3);

        // level raised mid-count steps on the next tick
        do_reset(1'b0);
        i_Level = 7'd0;
        ticks(4, 1);
        i_Level = 7'd6;
        st0_cnt = 0;
        ticks(1, 1);
        check("lvl_raise", 32'(st0_cnt), 1);

        // collision: car steps onto frog, persistent contact, frog re-entry
        do_reset(1'b0);
        i_Level = 7'd0;
        i_Frog_X = 5'd1;
        i_Frog_Y = 4'd12;
        col_cnt = 0;
        ticks(8, 2);
        check("col_first", 32'(col_cnt), 1);
        idle(20);
        check("col_hold", 32'(col_cnt), 1);
        i_Frog_X = 5'd2;
        idle(3);
        i_Frog_X = 5'd1;
        idle(3);
        check("col_again", 32'(col_cnt), 2);

        // frozen traffic: no motion, no collision; re-enable pulses once
        i_Enable = 1'b0;
        i_Frog_X = 5'd8;
        col_cnt = 0;
        ticks(20, 1);
        check("frozen_col", 32'(col_cnt), 0);
        query(8, 12);
        check("frozen_pos", 32'(o_Car_Hit), 1);
        i_Enable = 1'b1;
        idle(3);
        check("reenable_col", 32'(col_cnt), 1);

        // reset together with a frame tick restores initial positions
        i_Level = 7'd10;
        ticks(7, 1);
        do_reset(1'b1);
        query(7, 12);
        check("rst_q7_hit", 32'(o_Car_Hit), 1);
        check("rst_q7_dir", 32'(o_Car_Dir), 1);
        query(8, 12);
        check("rst_q8_hit", 32'(o_Car_Hit), 0);
        scan();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
